// File: rtl/proc_sequencer.sv
// -----------------------------------------------------------------------------
// proc_sequencer
//
// Per-core execution sequencer that sits around the opcode decoder. It fetches
// each instruction from instruction memory, holds it for one decode cycle, and
// then commits the decoder's enables as single-cycle strobes. Pulse, sync and
// fproc instructions are stalled until their time or handshake condition is
// met. The sequencer owns the instruction pointer: increment, jump, and
// ALU-conditional jump.
//
// Handshake semantics:
//   sync_req / fproc_req are level requests. Each is high from the first wait
//   cycle up to and including the cycle in which sync_ack / fproc_valid is
//   seen, and it drops on the following cycle. An ack or valid that arrives
//   outside the matching wait state is ignored.
//
// Ports:
//   clk, rst_n          core clock (rising edge), asynchronous active-low reset
//   start               leave IDLE/DONE and run from instr_ptr 0
//   abort               synchronous stop back to IDLE; beats every other event
//   is_pulse .. is_halt decoded instruction class (valid in DECODE onward)
//   reg_write_en        decoder register-write enable
//   qclk_load_en        decoder qclk-load enable
//   instr_ptr_load_en   00 incr, 01 jump, 10 jump if alu_cond, 11 incr
//   alu_cond            ALU compare result
//   jump_addr           jump target
//   pulse_time, qclk    pulse issue time and current qclk (unsigned compare)
//   sync_ack            sync handshake completion
//   fproc_valid         fproc data valid
//   instr_ptr           instruction memory address
//   mem_en, instr_load  memory read enable / instruction-register latch
//   cstrobe             one-cycle pulse issue strobe
//   reg_write_strobe    one-cycle register-file write
//   qclk_load_strobe    one-cycle qclk load
//   sync_req, fproc_req level requests (see above)
//   pulse_late          sticky: some pulse issued after its pulse_time
//   done                halted
// -----------------------------------------------------------------------------
module proc_sequencer #(
    parameter int INSTR_PTR_WIDTH  = 8,
    parameter int QCLK_WIDTH       = 32,
    parameter int MEM_READ_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       is_pulse,
    input  logic                       is_sync,
    input  logic                       is_fproc,
    input  logic                       is_halt,
    input  logic                       reg_write_en,
    input  logic                       qclk_load_en,
    input  logic [1:0]                 instr_ptr_load_en,
    input  logic                       alu_cond,
    input  logic [INSTR_PTR_WIDTH-1:0] jump_addr,
    input  logic [QCLK_WIDTH-1:0]      pulse_time,
    input  logic [QCLK_WIDTH-1:0]      qclk,
    input  logic                       sync_ack,
    input  logic                       fproc_valid,
    output logic [INSTR_PTR_WIDTH-1:0] instr_ptr,
    output logic                       mem_en,
    output logic                       instr_load,
    output logic                       cstrobe,
    output logic                       reg_write_strobe,
    output logic                       qclk_load_strobe,
    output logic                       sync_req,
    output logic                       fproc_req,
    output logic                       pulse_late,
    output logic                       done
);

    // Latency counter width; a one-cycle memory still needs a 1-bit counter.
    localparam int CNT_W = (MEM_READ_LATENCY > 1) ? $clog2(MEM_READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_DECODE     = 3'd2,
        S_EXEC       = 3'd3,
        S_PULSE_WAIT = 3'd4,
        S_SYNC_WAIT  = 3'd5,
        S_FPROC_WAIT = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    state_t                       state_q, state_d;
    logic [INSTR_PTR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         late_q, late_d;

    logic [INSTR_PTR_WIDTH-1:0]   ptr_inc;
    logic                         time_reached;
    logic                         time_passed;

    // Natural wrap from all-ones back to zero.
    assign ptr_inc      = ptr_q + INSTR_PTR_WIDTH'(1);
    assign time_reached = (qclk >= pulse_time);
    assign time_passed  = (qclk > pulse_time);

    assign instr_ptr  = ptr_q;
    assign pulse_late = late_q;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            late_q  <= late_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, datapath next values and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        cnt_d            = cnt_q;
        late_d           = late_q;
        mem_en           = 1'b0;
        instr_load       = 1'b0;
        cstrobe          = 1'b0;
        reg_write_strobe = 1'b0;
        qclk_load_strobe = 1'b0;
        sync_req         = 1'b0;
        fproc_req        = 1'b0;
        done             = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    late_d  = 1'b0;
                end
            end

            S_FETCH: begin
                mem_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    instr_load = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_DECODE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DECODE: begin
                // done is raised as soon as the halt is decoded, so the core
                // reports halted in the same cycle the halt is recognised.
                if (is_halt) begin
                    done    = 1'b1;
                    state_d = S_DONE;
                end else if (is_pulse) begin
                    state_d = S_PULSE_WAIT;
                end else if (is_sync) begin
                    state_d = S_SYNC_WAIT;
                end else if (is_fproc) begin
                    state_d = S_FPROC_WAIT;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                reg_write_strobe = reg_write_en;
                qclk_load_strobe = qclk_load_en;
                unique case (instr_ptr_load_en)
                    2'b01:   ptr_d = jump_addr;
                    2'b10:   ptr_d = alu_cond ? jump_addr : ptr_inc;
                    default: ptr_d = ptr_inc;
                endcase
                cnt_d   = '0;
                state_d = S_FETCH;
            end

            S_PULSE_WAIT: begin
                if (time_reached) begin
                    cstrobe = 1'b1;
                    if (time_passed) begin
                        late_d = 1'b1;
                    end
                    ptr_d   = ptr_inc;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end

            S_SYNC_WAIT: begin
                sync_req = 1'b1;
                if (sync_ack) begin
                    ptr_d   = ptr_inc;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end

            S_FPROC_WAIT: begin
                fproc_req = 1'b1;
                // EXEC then commits the register write or jump of this fproc.
                if (fproc_valid) begin
                    state_d = S_EXEC;
                end
            end

            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = S_FETCH;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    late_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // abort wins over everything: nothing coincident is committed, and
        // the core is back in its reset-like IDLE condition on the next cycle.
        if (abort) begin
            state_d          = S_IDLE;
            ptr_d            = '0;
            cnt_d            = '0;
            late_d           = 1'b0;
            instr_load       = 1'b0;
            cstrobe          = 1'b0;
            reg_write_strobe = 1'b0;
            qclk_load_strobe = 1'b0;
            done             = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_proc_sequencer
//
// Directed bench for proc_sequencer (defaults: IPW=8, QCLK=32, LAT=2).
// A small instruction table stands in for memory + decoder: every cycle the
// decoder inputs are taken from the table entry at the current instr_ptr.
// Each run starts with start high in cycle 0; outputs are logged per cycle at
// the falling edge and compared against hand-derived cycle numbers.
// -----------------------------------------------------------------------------
module tb_proc_sequencer;

    localparam int IPW  = 8;
    localparam int QW   = 32;
    localparam int LOGN = 200;

    // Instruction table encoding: {halt,pulse,sync,fproc,rwe,qle,load_en[1:0]}
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_HALT  = 8'h80;
    localparam logic [7:0] OP_PULSE = 8'h40;
    localparam logic [7:0] OP_SYNC  = 8'h20;
    localparam logic [7:0] OP_FPROC = 8'h10;
    localparam logic [7:0] OP_RWE   = 8'h08;
    localparam logic [7:0] OP_QLE   = 8'h04;
    localparam logic [7:0] OP_JCOND = 8'h02;
    localparam logic [7:0] OP_JMP   = 8'h01;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start, abort;
    logic           is_pulse, is_sync, is_fproc, is_halt;
    logic           reg_write_en, qclk_load_en;
    logic [1:0]     instr_ptr_load_en;
    logic           alu_cond;
    logic [IPW-1:0] jump_addr;
    logic [QW-1:0]  pulse_time, qclk;
    logic           sync_ack, fproc_valid;
    logic [IPW-1:0] instr_ptr;
    logic           mem_en, instr_load, cstrobe, reg_write_strobe, qclk_load_strobe;
    logic           sync_req, fproc_req, pulse_late, done;

    proc_sequencer #(
        .INSTR_PTR_WIDTH (IPW),
        .QCLK_WIDTH      (QW),
        .MEM_READ_LATENCY(2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .is_pulse         (is_pulse),
        .is_sync          (is_sync),
        .is_fproc         (is_fproc),
        .is_halt          (is_halt),
        .reg_write_en     (reg_write_en),
        .qclk_load_en     (qclk_load_en),
        .instr_ptr_load_en(instr_ptr_load_en),
        .alu_cond         (alu_cond),
        .jump_addr        (jump_addr),
        .pulse_time       (pulse_time),
        .qclk             (qclk),
        .sync_ack         (sync_ack),
        .fproc_valid      (fproc_valid),
        .instr_ptr        (instr_ptr),
        .mem_en           (mem_en),
        .instr_load       (instr_load),
        .cstrobe          (cstrobe),
        .reg_write_strobe (reg_write_strobe),
        .qclk_load_strobe (qclk_load_strobe),
        .sync_req         (sync_req),
        .fproc_req        (fproc_req),
        .pulse_late       (pulse_late),
        .done             (done)
    );

    // ---------------- stimulus state ----------------
    logic [7:0] imem [0:255];
    int cyc;
    int start_at, start2_at, abort_at, ack_at, valid_at;
    logic qclk_run;

    logic [IPW-1:0] log_ptr  [0:LOGN-1];
    logic           log_men  [0:LOGN-1];
    logic           log_load [0:LOGN-1];
    logic           log_cs   [0:LOGN-1];
    logic           log_rw   [0:LOGN-1];
    logic           log_ql   [0:LOGN-1];
    logic           log_sreq [0:LOGN-1];
    logic           log_freq [0:LOGN-1];
    logic           log_late [0:LOGN-1];
    logic           log_done [0:LOGN-1];

    int n_vec = 0;
    int n_err = 0;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = OP_NOP;
    endtask

    // One clock cycle: drive inputs for cycle 'cyc', log outputs at negedge.
    task automatic cycle();
        logic [7:0] ins;
        start       = (cyc == start_at) || (cyc == start2_at);
        abort       = (cyc == abort_at);
        sync_ack    = (cyc == ack_at);
        fproc_valid = (cyc == valid_at);
        ins = imem[instr_ptr];
        is_halt           = ins[7];
        is_pulse          = ins[6];
        is_sync           = ins[5];
        is_fproc          = ins[4];
        reg_write_en      = ins[3];
        qclk_load_en      = ins[2];
        instr_ptr_load_en = ins[1:0];
        @(negedge clk);
        if (cyc < LOGN) begin
            log_ptr[cyc]  = instr_ptr;
            log_men[cyc]  = mem_en;
            log_load[cyc] = instr_load;
            log_cs[cyc]   = cstrobe;
            log_rw[cyc]   = reg_write_strobe;
            log_ql[cyc]   = qclk_load_strobe;
            log_sreq[cyc] = sync_req;
            log_freq[cyc] = fproc_req;
            log_late[cyc] = pulse_late;
            log_done[cyc] = done;
        end
        @(posedge clk);
        #1;
        if (qclk_run) qclk = qclk + 32'd1;
        cyc++;
    endtask

    task automatic begin_run();
        cyc       = 0;
        start_at  = 0;
        start2_at = -1;
        abort_at  = -1;
        ack_at    = -1;
        valid_at  = -1;
    endtask

    task automatic run(input int last);
        while (cyc <= last) cycle();
    endtask

    // ---------------- tests ----------------
    initial begin
        int cnt;
        start = 0; abort = 0; sync_ack = 0; fproc_valid = 0;
        is_pulse = 0; is_sync = 0; is_fproc = 0; is_halt = 0;
        reg_write_en = 0; qclk_load_en = 0; instr_ptr_load_en = 2'b00;
        alu_cond = 0; jump_addr = '0; pulse_time = '0; qclk = '0; qclk_run = 0;
        clear_imem();

        // Reset state
        begin_run();
        start_at = -1;
        @(posedge clk);
        #1;
        run(1);
        check("rst_ptr",   {24'd0, log_ptr[1]}, 32'd0);
        check("rst_mem_en", log_men[1], 0);
        check("rst_done",   log_done[1], 0);
        check("rst_late",   log_late[1], 0);
        check("rst_sreq",   log_sreq[1], 0);
        rst_n = 1'b1;
        #2;

        // 1. reg write at 0, halt at 1
        clear_imem();
        imem[0] = OP_RWE | OP_QLE;
        imem[1] = OP_HALT;
        begin_run();
        run(9);
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("t1_load_c%0d", c), log_load[c], (c == 2 || c == 6));
            check($sformatf("t1_rw_c%0d", c),   log_rw[c],   (c == 4));
            check($sformatf("t1_done_c%0d", c), log_done[c], (c >= 7));
        end
        check("t1_qload_c4", log_ql[4], 1);
        check("t1_mem_en_c1", log_men[1], 1);
        check("t1_mem_en_c3", log_men[3], 0);
        check("t1_ptr_c9", {24'd0, log_ptr[9]}, 32'd1);

        // 2a. pulse on time: qclk 90 at DECODE (cycle 3), hits 100 at cycle 13
        clear_imem();
        imem[0] = OP_PULSE;
        imem[1] = OP_HALT;
        pulse_time = 32'd100;
        qclk = 32'd87;
        qclk_run = 1;
        begin_run();
        run(18);
        for (int c = 1; c <= 15; c++)
            check($sformatf("t2a_cs_c%0d", c), log_cs[c], (c == 13));
        check("t2a_late_c14", log_late[14], 0);
        check("t2a_ptr_c14", {24'd0, log_ptr[14]}, 32'd1);
        check("t2a_done_c18", log_done[18], 1);

        // 2b. pulse late: qclk 120 at DECODE -> issue in first wait cycle
        qclk = 32'd117;
        begin_run();
        run(8);
        for (int c = 1; c <= 8; c++)
            check($sformatf("t2b_cs_c%0d", c), log_cs[c], (c == 4));
        check("t2b_late_c4", log_late[4], 0);
        check("t2b_late_c5", log_late[5], 1);
        check("t2b_late_c8", log_late[8], 1);
        qclk_run = 0;

        // 3a. conditional jump taken at ptr 5
        clear_imem();
        imem[5]    = OP_JCOND;
        imem[6]    = OP_HALT;
        imem[8'h20] = OP_HALT;
        jump_addr = 8'h20;
        alu_cond = 1;
        begin_run();
        run(28);
        check("t3a_late_cleared", log_late[1], 0);
        check("t3a_ptr_c24", {24'd0, log_ptr[24]}, 32'd5);
        check("t3a_ptr_c25", {24'd0, log_ptr[25]}, 32'h20);
        check("t3a_done_c26", log_done[26], 0);
        check("t3a_done_c27", log_done[27], 1);

        // 3b. conditional jump not taken
        alu_cond = 0;
        begin_run();
        run(28);
        check("t3b_ptr_c25", {24'd0, log_ptr[25]}, 32'd6);
        check("t3b_done_c27", log_done[27], 1);

        // 3c. jump to 0xFF, increment wraps to 0; start mid-run ignored; abort
        clear_imem();
        imem[0] = OP_JMP;
        jump_addr = 8'hFF;
        begin_run();
        start2_at = 6;
        abort_at  = 10;
        run(11);
        check("t3c_ptr_c5", {24'd0, log_ptr[5]}, 32'hFF);
        check("t3c_ptr_c7", {24'd0, log_ptr[7]}, 32'hFF);
        check("t3c_ptr_c9", {24'd0, log_ptr[9]}, 32'd0);
        check("t3c_mem_en_c9", log_men[9], 1);
        check("t3c_mem_en_c11", log_men[11], 0);

        // 4a. sync, ack 7 cycles after entering SYNC_WAIT (cycle 4)
        clear_imem();
        imem[0] = OP_SYNC;
        imem[1] = OP_HALT;
        begin_run();
        ack_at = 11;
        run(15);
        cnt = 0;
        for (int c = 1; c <= 15; c++) cnt += int'(log_sreq[c]);
        check("t4_sreq_cycles", cnt, 8);
        check("t4_sreq_c11", log_sreq[11], 1);
        check("t4_sreq_c12", log_sreq[12], 0);
        check("t4_ptr_c11", {24'd0, log_ptr[11]}, 32'd0);
        check("t4_ptr_c12", {24'd0, log_ptr[12]}, 32'd1);
        check("t4_mem_en_c12", log_men[12], 1);
        check("t4_done_c14", log_done[14], 1);

        // 4b. fproc with register write, valid in cycle 6
        clear_imem();
        imem[0] = OP_FPROC | OP_RWE;
        imem[1] = OP_HALT;
        begin_run();
        valid_at = 6;
        run(11);
        check("t4f_freq_c3", log_freq[3], 0);
        check("t4f_freq_c4", log_freq[4], 1);
        check("t4f_freq_c6", log_freq[6], 1);
        check("t4f_freq_c7", log_freq[7], 0);
        check("t4f_rw_c6", log_rw[6], 0);
        check("t4f_rw_c7", log_rw[7], 1);
        check("t4f_rw_c8", log_rw[8], 0);
        check("t4f_ptr_c8", {24'd0, log_ptr[8]}, 32'd1);
        check("t4f_done_c11", log_done[11], 1);

        // 5a. abort coincident with sync_ack at ptr 1
        clear_imem();
        imem[1] = OP_SYNC;
        begin_run();
        ack_at   = 10;
        abort_at = 10;
        run(12);
        check("t5_sreq_c10", log_sreq[10], 1);
        check("t5_ptr_c10", {24'd0, log_ptr[10]}, 32'd1);
        check("t5_ptr_c11", {24'd0, log_ptr[11]}, 32'd0);
        check("t5_sreq_c11", log_sreq[11], 0);
        check("t5_mem_en_c11", log_men[11], 0);
        check("t5_mem_en_c12", log_men[12], 0);
        check("t5_done_c12", log_done[12], 0);

        // 5b. asynchronous reset while waiting in PULSE_WAIT at ptr 1
        clear_imem();
        imem[1] = OP_PULSE;
        pulse_time = 32'd1000;
        qclk = 32'd0;
        begin_run();
        run(9);
        check("t5r_ptr_before", {24'd0, log_ptr[9]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5r_async_ptr", {24'd0, instr_ptr}, 32'd0);
        check("t5r_async_mem_en", mem_en, 0);
        check("t5r_async_cs", cstrobe, 0);
        check("t5r_async_done", done, 0);
        check("t5r_async_late", pulse_late, 0);
        #3;
        rst_n = 1'b1;
        begin_run();
        start_at = -1;
        qclk = 32'd2000;
        run(3);
        check("t5r_idle_mem_en", log_men[2], 0);
        check("t5r_idle_cs", log_cs[2], 0);
        check("t5r_idle_ptr", {24'd0, log_ptr[3]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
